// File: rtl/xorshift_pkg.sv
// Shared constants and types for the xorshift+ random word source.
//   DEF_SHIFT0..2  default shift amounts of the xorshift+ step
//   DEF_SEED0/1    default state words loaded at reset (64-bit, truncated by users)
//   state_t        sequencing states of the stream controller
package xorshift_pkg;

  localparam int DEF_SHIFT0 = 23;
  localparam int DEF_SHIFT1 = 18;
  localparam int DEF_SHIFT2 = 5;

  localparam logic [63:0] DEF_SEED0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DEF_SEED1 = 64'hFEDC_BA98_7654_3210;

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/xorshift_plus_step.sv
// One combinational xorshift+ step.
//   s0, s1  current state words
//   nxt     new state0 (state1 takes the old s0)
//   word    output word for this step, s0 + nxt modulo 2^BITSIZE
module xorshift_plus_step
  import xorshift_pkg::*;
#(
  parameter int BITSIZE = 64,
  parameter int SHIFT0  = DEF_SHIFT0,
  parameter int SHIFT1  = DEF_SHIFT1,
  parameter int SHIFT2  = DEF_SHIFT2
) (
  input  logic [BITSIZE-1:0] s0,
  input  logic [BITSIZE-1:0] s1,
  output logic [BITSIZE-1:0] nxt,
  output logic [BITSIZE-1:0] word
);

  logic [BITSIZE-1:0] x_a;
  logic [BITSIZE-1:0] x_b;

  assign x_a  = s1 ^ (s1 << SHIFT0);
  assign x_b  = x_a ^ (x_a >> SHIFT1);
  assign nxt  = x_b ^ s0 ^ (s0 >> SHIFT2);
  assign word = s0 + nxt;

endmodule

// File: rtl/xorshift_plus_stream.sv
// xorshift+ random word source with a valid/ready output stream.
//   clk, rst             clock, synchronous active-high reset
//   seed_valid/seed0/1   load a new state pair (always accepted)
//   out_valid/ready/data output stream, one word per cycle when ready stays high
//   warming              high while discarding warm-up steps
//   seed_fixed           last loaded seed pair was all-zero and got corrected
//   words_out            completed output handshakes, wrapping counter
//
// state     | meaning
// ST_WARMUP | discarding WARMUP steps after reset or a seed load
// ST_RUN    | feeding step words into the output register
module xorshift_plus_stream
  import xorshift_pkg::*;
#(
  parameter int                BITSIZE       = 64,
  parameter int                SHIFT0        = DEF_SHIFT0,
  parameter int                SHIFT1        = DEF_SHIFT1,
  parameter int                SHIFT2        = DEF_SHIFT2,
  parameter int                WARMUP        = 16,
  parameter logic [BITSIZE-1:0] DEFAULT_SEED0 = BITSIZE'(DEF_SEED0),
  parameter logic [BITSIZE-1:0] DEFAULT_SEED1 = BITSIZE'(DEF_SEED1),
  parameter int                COUNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_valid,
  input  logic [BITSIZE-1:0] seed0,
  input  logic [BITSIZE-1:0] seed1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] out_data,
  output logic               warming,
  output logic               seed_fixed,
  output logic [COUNT_W-1:0] words_out
);

  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP);
  localparam state_t ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BITSIZE-1:0] s0;
  logic [BITSIZE-1:0] s1;
  logic [BITSIZE-1:0] nxt;
  logic [BITSIZE-1:0] word;
  logic               load;
  logic               seed_zero;

  xorshift_plus_step #(
    .BITSIZE (BITSIZE),
    .SHIFT0  (SHIFT0),
    .SHIFT1  (SHIFT1),
    .SHIFT2  (SHIFT2)
  ) u_step (
    .s0   (s0),
    .s1   (s1),
    .nxt  (nxt),
    .word (word)
  );

  assign load      = !out_valid || out_ready;
  assign seed_zero = (seed0 == '0) && (seed1 == '0);
  assign warming   = (state == ST_WARMUP);

  always_ff @(posedge clk) begin
    if (rst) begin
      s0         <= DEFAULT_SEED0;
      s1         <= DEFAULT_SEED1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      words_out  <= '0;
      seed_fixed <= 1'b0;
      cnt        <= CNT_INIT;
      state      <= ST_INIT;
    end else begin
      // A handshake in the same cycle as a seed load still completes.
      if (out_valid && out_ready) begin
        words_out <= words_out + COUNT_W'(1);
      end

      if (seed_valid) begin
        s0        <= seed0;
        // An all-zero state is a fixed point of the generator.
        s1        <= seed_zero ? BITSIZE'(1) : seed1;
        seed_fixed <= seed_zero;
        out_valid <= 1'b0;
        cnt       <= CNT_INIT;
        state     <= ST_INIT;
      end else begin
        case (state)
          ST_WARMUP: begin
            s0  <= nxt;
            s1  <= s0;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            // State only advances when a word enters the output register,
            // so stalls neither skip nor repeat words.
            if (load) begin
              out_data  <= word;
              out_valid <= 1'b1;
              s0        <= nxt;
              s1        <= s0;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xorshift_plus_stream.sv
module tb_xorshift_plus_stream;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // main instance: WARMUP=16, COUNT_W=32
  logic        seed_valid = 1'b0;
  logic [63:0] seed0 = '0;
  logic [63:0] seed1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        warming;
  logic        seed_fixed;
  logic [31:0] words_out;

  // second instance: WARMUP=0, COUNT_W=4
  logic        z_seed_valid = 1'b0;
  logic [63:0] z_seed0 = '0;
  logic [63:0] z_seed1 = '0;
  logic        z_out_valid;
  logic        z_out_ready = 1'b0;
  logic [63:0] z_out_data;
  logic        z_warming;
  logic        z_seed_fixed;
  logic [3:0]  z_words_out;

  int checks = 0;
  int errors = 0;

  logic [63:0] ms0, ms1;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  xorshift_plus_stream #(.WARMUP(16)) dut (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid), .seed0(seed0), .seed1(seed1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .warming(warming), .seed_fixed(seed_fixed), .words_out(words_out)
  );

  xorshift_plus_stream #(.WARMUP(0), .COUNT_W(4)) dut_z (
    .clk(clk), .rst(rst),
    .seed_valid(z_seed_valid), .seed0(z_seed0), .seed1(z_seed1),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .warming(z_warming), .seed_fixed(z_seed_fixed), .words_out(z_words_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_next(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] t;
    t = b ^ (b << 23);
    t = t ^ (t >> 18);
    return t ^ a ^ (a >> 5);
  endfunction

  task automatic model_adv(output logic [63:0] w);
    logic [63:0] n;
    n   = ref_next(ms0, ms1);
    w   = ms0 + n;
    ms1 = ms0;
    ms0 = n;
  endtask

  task automatic model_seed(input logic [63:0] a, input logic [63:0] b, input int warm);
    logic [63:0] w;
    exp_q.delete();
    ms0 = a;
    ms1 = (a == 64'h0 && b == 64'h0) ? 64'h1 : b;
    repeat (warm) model_adv(w);
  endtask

  task automatic model_push(input int n);
    logic [63:0] w;
    repeat (n) begin
      model_adv(w);
      exp_q.push_back(w);
    end
  endtask

  // Called at the negedge right after the seed/reset edge.
  task automatic measure_latency(input string tag);
    int k;
    int wcnt;
    k = 0;
    wcnt = 0;
    out_ready = 1'b1;
    while (!out_valid && k < 60) begin
      if (warming) wcnt++;
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'd17);
    check({tag, " warm_cycles"}, 64'(wcnt), 64'd16);
  endtask

  task automatic stream(input string tag, input int n, input bit rnd);
    int got;
    int cyc;
    logic pv, pr;
    logic [63:0] pd, e;
    got = 0;
    cyc = 0;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    while (got < n && cyc < 40 * n + 100) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr) begin
        check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, " hold_data"}, out_data, pd);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        check({tag, " word"}, out_data, e);
        got++;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, " delivered"}, 64'(got), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", out_data, 64'd0);
    check("rst words_out", 64'(words_out), 64'd0);
    check("rst seed_fixed", 64'(seed_fixed), 64'd0);
    check("rst warming", 64'(warming), 64'd1);
    check("rst z_warming", 64'(z_warming), 64'd0);
    check("rst z_words_out", 64'(z_words_out), 64'd0);

    // default-seed sequence after reset
    rst = 1'b0;
    model_seed(D0, D1, 16);
    model_push(8);
    measure_latency("boot");
    stream("boot", 8, 1'b0);
    check("boot words_out", 64'(words_out), 64'd8);

    // reseed, then 1000 words under random backpressure
    seed_valid = 1'b1;
    seed0 = 64'hDEAD_BEEF_0000_1111;
    seed1 = 64'h1234_0000_ABCD_9876;
    model_seed(seed0, seed1, 16);
    model_push(1000);
    @(negedge clk);
    seed_valid = 1'b0;
    check("seed2 seed_fixed", 64'(seed_fixed), 64'd0);
    measure_latency("seed2");
    stream("bp", 1000, 1'b1);
    check("bp words_out", 64'(words_out), 64'd1008);

    // reseed while a transfer completes in the same cycle
    check("pre_reseed out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    seed_valid = 1'b1;
    seed0 = 64'h0F0F_F0F0_1234_5678;
    seed1 = 64'h0000_0000_0000_0042;
    model_seed(seed0, seed1, 16);
    model_push(5);
    @(negedge clk);
    seed_valid = 1'b0;
    check("reseed out_valid", 64'(out_valid), 64'd0);
    check("reseed words_out", 64'(words_out), 64'd1009);
    check("reseed warming", 64'(warming), 64'd1);
    measure_latency("reseed");
    stream("reseed", 5, 1'b0);
    check("reseed words_after", 64'(words_out), 64'd1014);

    // all-zero seed, then rst in the middle of warm-up
    seed_valid = 1'b1;
    seed0 = '0;
    seed1 = '0;
    @(negedge clk);
    seed_valid = 1'b0;
    check("zero seed_fixed", 64'(seed_fixed), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst words_out", 64'(words_out), 64'd0);
    check("midrst seed_fixed", 64'(seed_fixed), 64'd0);
    model_seed(D0, D1, 16);
    model_push(3);
    measure_latency("midrst");
    stream("midrst", 3, 1'b0);
    check("midrst words_after", 64'(words_out), 64'd3);

    // WARMUP=0 instance: known first words
    z_seed_valid = 1'b1;
    z_seed0 = 64'h1;
    z_seed1 = 64'h0;
    z_out_ready = 1'b0;
    @(negedge clk);
    z_seed_valid = 1'b0;
    check("z seed out_valid", 64'(z_out_valid), 64'd0);
    z_out_ready = 1'b1;
    @(negedge clk);
    check("z first valid", 64'(z_out_valid), 64'd1);
    check("z first word", z_out_data, 64'h2);
    @(negedge clk);
    z_out_ready = 1'b0;
    check("z second word", z_out_data, 64'h0000_0000_0080_0021);
    check("z seed_fixed", 64'(z_seed_fixed), 64'd0);
    check("z words_out", 64'(z_words_out), 64'd1);

    // zero seed on WARMUP=0 instance, then wrap of 4-bit counter
    z_seed_valid = 1'b1;
    z_seed0 = '0;
    z_seed1 = '0;
    @(negedge clk);
    z_seed_valid = 1'b0;
    check("z zero seed_fixed", 64'(z_seed_fixed), 64'd1);
    check("z zero out_valid", 64'(z_out_valid), 64'd0);
    z_out_ready = 1'b1;
    @(negedge clk);
    check("z zero first word", z_out_data, 64'h0000_0000_0080_0021);
    check("z zero words_out", 64'(z_words_out), 64'd1);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      check($sformatf("z wrap %0d", j), 64'(z_words_out), 64'((1 + j) % 16));
    end
    z_out_ready = 1'b0;
    z_seed_valid = 1'b1;
    z_seed0 = 64'h5;
    z_seed1 = 64'h7;
    @(negedge clk);
    z_seed_valid = 1'b0;
    check("z reseed seed_fixed", 64'(z_seed_fixed), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
